// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO feeding a UART transmit handshake.
// Writers push bytes at full clock rate; an issue FSM hands them one at a time
// to the UART as a single-cycle enable pulse and waits out the frame on busy.
// Optional feature macro: UART_TX_QUEUE_CRLF_EN (expand LF into CR,LF on the wire).
module uart_tx_queue #(
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wrEnable,
    input  logic [7:0]            wrData,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   level,
    output logic                  overflow,
    output logic                  busy,
    output logic                  uartTxEnable,
    output logic [7:0]            uartTxData,
    input  logic                  uartTxBusy
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] DEPTH_CNT = {1'b1, {DEPTH_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

    state_t                 state, state_next;
    logic [7:0]             mem [DEPTH];
    logic [DEPTH_BITS-1:0]  rd_ptr, wr_ptr;
    logic [DEPTH_BITS:0]    count;
    logic                   push, pop, issue;
    logic [7:0]             head, issue_data;
`ifdef UART_TX_QUEUE_CRLF_EN
    logic                   cr_flag, cr_set, cr_clr;
`endif

    // full is taken from the registered count, so a write on a full queue is
    // dropped even if the FSM pops on the same edge.
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);
    assign level = count;
    assign busy  = !empty || (state != IDLE);
    assign head  = mem[rd_ptr];
    assign push  = wrEnable && !full;

    // Issue FSM: next state, pop and the byte to launch this edge.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        issue_data = head;
`ifdef UART_TX_QUEUE_CRLF_EN
        cr_set     = 1'b0;
        cr_clr     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty && !uartTxBusy) begin
                    issue      = 1'b1;
                    state_next = HOLD;
`ifdef UART_TX_QUEUE_CRLF_EN
                    // First visit to a queued LF sends CR and leaves LF at the head.
                    if (head == 8'h0A && !cr_flag) begin
                        issue_data = 8'h0D;
                        cr_set     = 1'b1;
                    end else begin
                        pop    = 1'b1;
                        cr_clr = 1'b1;
                    end
`else
                    pop = 1'b1;
`endif
                end
            end
            // The UART raises busy one cycle after it samples enable, so busy is
            // not trustworthy here; just drop enable and move on.
            HOLD:    state_next = WAIT;
            WAIT:    if (!uartTxBusy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed since it is only read when non-empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wrData;
    end

    // UART-facing registers; data holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uartTxEnable <= 1'b0;
            uartTxData   <= 8'h00;
            overflow     <= 1'b0;
        end else begin
            overflow     <= wrEnable && full;
            uartTxEnable <= issue;
            if (issue) uartTxData <= issue_data;
        end
    end

`ifdef UART_TX_QUEUE_CRLF_EN
    // CR-already-sent marker for the LF sitting at the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cr_flag <= 1'b0;
        else if (cr_set) cr_flag <= 1'b1;
        else if (cr_clr) cr_flag <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Testbench for uart_tx_queue: directed writes, a simple UART busy model,
// and a scoreboard of expected bytes checked by an independent monitor.
// Honors UART_TX_QUEUE_CRLF_EN for the LF expansion case.
module tb_uart_tx_queue;

    localparam int FRAME = 20;  // UART frame time in clocks for the model

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wrEnable = 1'b0;
    logic [7:0] wrData = 8'h00;
    logic       full, empty, overflow, busy, uartTxEnable, uartTxBusy;
    logic [4:0] level;
    logic [7:0] uartTxData;

    logic       force_busy = 1'b0;
    int         frame_cnt = 0;
    int         n_pass = 0;
    int         n_total = 0;
    int         pulses = 0;
    int         ovf_cnt = 0;
    logic       prev_en = 1'b0;
    logic [7:0] exp_q[$];

    uart_tx_queue #(.DEPTH_BITS(4)) dut (
        .clk(clk), .rst(rst), .wrEnable(wrEnable), .wrData(wrData),
        .full(full), .empty(empty), .level(level), .overflow(overflow),
        .busy(busy), .uartTxEnable(uartTxEnable), .uartTxData(uartTxData),
        .uartTxBusy(uartTxBusy)
    );

    always #5 clk = ~clk;

    // UART model: samples enable on posedge, busy from the next cycle for FRAME clocks.
    always @(posedge clk) begin
        if (frame_cnt != 0)    frame_cnt <= frame_cnt - 1;
        else if (uartTxEnable) frame_cnt <= FRAME;
    end
    assign uartTxBusy = (frame_cnt != 0) || force_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: every enable pulse pops one expected byte; pulses must be 1 cycle wide.
    always @(negedge clk) begin
        if (!rst) begin
            if (overflow) ovf_cnt++;
            if (uartTxEnable) begin
                pulses++;
                check("pulse_width", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_tx: got %0h expected none at %0t", uartTxData, $time);
                end else begin
                    check("tx_byte", {24'd0, uartTxData}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        prev_en = uartTxEnable;
    end

    task automatic write_byte(input logic [7:0] b, input bit expect_tx);
        wrEnable = 1'b1;
        wrData   = b;
        if (expect_tx) exp_q.push_back(b);
        @(posedge clk); #1;
        wrEnable = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && !uartTxBusy) break;
        end
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_empty",  {31'd0, empty}, 32'd1);
        check("rst_full",   {31'd0, full}, 32'd0);
        check("rst_level",  {27'd0, level}, 32'd0);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_en",     {31'd0, uartTxEnable}, 32'd0);
        check("rst_data",   {24'd0, uartTxData}, 32'd0);
        check("rst_ovf",    {31'd0, overflow}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // 1: single byte latency
        @(posedge clk); #1;
        write_byte(8'h41, 1'b1);               // edge N
        @(negedge clk);
        check("t1_level_n",  {27'd0, level}, 32'd1);
        check("t1_en_n",     {31'd0, uartTxEnable}, 32'd0);
        @(negedge clk);                        // after N+1
        check("t1_en_n1",    {31'd0, uartTxEnable}, 32'd1);
        check("t1_data_n1",  {24'd0, uartTxData}, 32'h41);
        check("t1_level_n1", {27'd0, level}, 32'd0);
        @(negedge clk);                        // after N+2
        check("t1_en_n2",    {31'd0, uartTxEnable}, 32'd0);
        check("t1_data_hold",{24'd0, uartTxData}, 32'h41);
        wait_idle("t1");

        // 2: burst of 16; one pop happens during the burst so 15 remain
        for (int i = 0; i < 16; i++) write_byte(8'h30 + 8'(i), 1'b1);
        @(negedge clk);
        check("t2_level", {27'd0, level}, 32'd15);
        check("t2_full",  {31'd0, full}, 32'd0);
        wait_idle("t2");
        check("t2_no_ovf", ovf_cnt, 32'd0);

        // 3: fill with UART held busy, then overflow
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h50 + 8'(i), 1'b1);
        @(negedge clk);
        check("t3_full",  {31'd0, full}, 32'd1);
        check("t3_level", {27'd0, level}, 32'd16);
        @(posedge clk); #1;
        write_byte(8'hFF, 1'b0);
        @(negedge clk);
        check("t3_ovf_hi",  {31'd0, overflow}, 32'd1);
        check("t3_level_a", {27'd0, level}, 32'd16);
        @(negedge clk);
        check("t3_ovf_lo",  {31'd0, overflow}, 32'd0);
        check("t3_level_b", {27'd0, level}, 32'd16);
        check("t3_ovf_cnt", ovf_cnt, 32'd1);
        #1 force_busy = 1'b0;
        wait_idle("t3");

        // 4: move pointers to 11, queue 5 bytes across the wrap, then push+pop
        for (int i = 0; i < 10; i++) write_byte(8'hA0 + 8'(i), 1'b1);
        wait_idle("t4_pre");
        force_busy = 1'b1;
        for (int i = 0; i < 5; i++) write_byte(8'h60 + 8'(i), 1'b1);
        @(negedge clk);
        check("t4_level5", {27'd0, level}, 32'd5);
        @(posedge clk); #1;
        force_busy = 1'b0;
        write_byte(8'h65, 1'b1);               // same edge as the first pop
        @(negedge clk);
        check("t4_level_same", {27'd0, level}, 32'd5);
        check("t4_en",         {31'd0, uartTxEnable}, 32'd1);
        wait_idle("t4");

        // 5: reset while waiting on the UART with 7 queued
        for (int i = 0; i < 8; i++) write_byte(8'h70 + 8'(i), (i == 0));
        @(negedge clk);
        check("t5_level7", {27'd0, level}, 32'd7);
        check("t5_busy",   {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5_empty", {31'd0, empty}, 32'd1);
        check("t5_busy0", {31'd0, busy}, 32'd0);
        check("t5_en0",   {31'd0, uartTxEnable}, 32'd0);
        check("t5_lvl0",  {27'd0, level}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        p0 = pulses;
        repeat (60) @(negedge clk);
        check("t5_no_pulse", pulses, p0);
        wait_idle("t5");

        // 6: LF handling
        p0 = pulses;
        exp_q.push_back(8'h41);
`ifdef UART_TX_QUEUE_CRLF_EN
        exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(8'h0A);
        write_byte(8'h41, 1'b0);
        write_byte(8'h0A, 1'b0);
        wait_idle("t6");
`ifdef UART_TX_QUEUE_CRLF_EN
        check("t6_pulses", pulses - p0, 32'd3);
`else
        check("t6_pulses", pulses - p0, 32'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
